// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and baud/counter sizing helpers
//   No ports. Imported by uart_rx (and uart_tx) so both halves agree on
//   timing arithmetic and FSM encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } uart_state_e;

  // Clocks per bit on the line.
  function automatic int baud_div(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

  // Offset from start-edge detection to the middle of the start bit.
  function automatic int half_div(input int clk_rate, input int baud);
    return baud_div(clk_rate, baud) / 2;
  endfunction

  function automatic int baud_cnt_w(input int div);
    return $clog2(div) + 1;
  endfunction

  function automatic int bit_cnt_w(input int word_len);
    return $clog2(word_len + 1);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-character stream and status pulses of uart_rx
//   rx_data/rx_data_valid/rx_data_ready : byte handshake (master = receiver)
//   frame_err/overrun                   : single-cycle status pulses
interface uart_rx_if #(
  parameter int Word_len = 8
);
  logic [Word_len-1:0] rx_data;
  logic                rx_data_valid;
  logic                rx_data_ready;
  logic                frame_err;
  logic                overrun;

  modport master (
    output rx_data, rx_data_valid, frame_err, overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data, rx_data_valid, frame_err, overrun,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an idle-high async input
//   clk, rst : clock, synchronous active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronized output (resets to 1, the idle line level)
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 (parameterisable) UART receiver with byte handshake
//   clk, rst : clock, synchronous active-high reset
//   Uart_rx  : asynchronous serial line, idle high, LSB first
//   rx       : uart_rx_if.master - rx_data/valid/ready, frame_err, overrun
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_rate = 100000000,
  parameter int Baud     = 115200,
  parameter int Word_len = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      Uart_rx,
  uart_rx_if.master rx
);
  localparam int BaudDiv = baud_div(clk_rate, Baud);
  localparam int Half    = half_div(clk_rate, Baud);
  localparam int BcW     = baud_cnt_w(BaudDiv);
  localparam int BitW    = bit_cnt_w(Word_len);

  localparam logic [BcW-1:0]  BaudLast = BcW'(BaudDiv - 1);
  localparam logic [BcW-1:0]  HalfLast = BcW'(Half - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(Word_len - 1);

  logic rx_s;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (Uart_rx),
    .q_o (rx_s)
  );

  uart_state_e         state_q, state_d;
  logic [BcW-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [Word_len-1:0] shift_q, shift_d;
  logic                armed_q, armed_d;
  logic [1:0]          settle_q, settle_d;
  logic [Word_len-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                fe_q, fe_d;
  logic                ov_q, ov_d;
  logic                done;
  logic                settled;

  // The synchronizer leaves reset reading "idle"; those first two rx_s
  // samples are not the line, so they must not arm the start detector.
  assign settled = (settle_q == 2'd2);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    settle_d   = settle_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
    done       = 1'b0;

    if (!settled) settle_d = settle_q + 2'd1;
    if (valid_q && rx.rx_data_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (settled && rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) begin
          armed_d = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_cnt_q == HalfLast) begin
          baud_cnt_d = '0;
          state_d    = rx_s ? S_IDLE : S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BcW'(1);
        end
      end
      S_DATA: begin
        if (baud_cnt_q == BaudLast) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s, shift_q[Word_len-1:1]};
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BcW'(1);
        end
      end
      S_STOP: begin
        if (baud_cnt_q == BaudLast) begin
          baud_cnt_d = '0;
          if (rx_s) begin
            // Return to Idle mid-stop-bit to gain resync margin.
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BRK;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BcW'(1);
        end
      end
      S_BRK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A consumer taking the old character in the completion cycle frees
    // the register for the new one; otherwise the new one is dropped.
    if (done) begin
      if (!valid_q || rx.rx_data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      settle_q   <= 2'd0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      settle_q   <= settle_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

  assign rx.rx_data       = data_q;
  assign rx.rx_data_valid = valid_q;
  assign rx.frame_err     = fe_q;
  assign rx.overrun       = ov_q;
endmodule
